// File: rtl/mpq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpq_pkg
//  Description : Shared types and constants for the max-priority-queue
//                heap dump checker (FSM states, error codes, index sentinel).
//  Revision    : 1.0  initial release
// ============================================================================
package mpq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } chk_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HEAP = 2'd1;
  localparam logic [1:0] ERR_SEQ  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  localparam logic [7:0] IDX_NONE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/heap_cap_mem.sv
`default_nettype none
// ============================================================================
//  Module      : heap_cap_mem
//  Description : DEPTH x 8 capture buffer, one synchronous write port and
//                three asynchronous read ports (parent, child, read-back).
//  Revision    : 1.0  initial release
// ============================================================================
module heap_cap_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] par_addr,
  output logic [7:0]    par_data,
  input  logic [AW-1:0] chd_addr,
  output logic [7:0]    chd_data,
  input  logic [AW-1:0] rb_addr,
  output logic [7:0]    rb_data
);

  // Contents are intentionally not reset: they only matter once written.
  logic [7:0] mem [DEPTH];

  // Single write port, writes gated by the caller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign par_data = mem[par_addr];
  assign chd_data = mem[chd_addr];
  assign rb_data  = mem[rb_addr];

endmodule
`default_nettype wire

// File: rtl/heap_dump_checker.sv
`default_nettype none
// ============================================================================
//  Module      : heap_dump_checker
//  Description : Captures a heap array streamed over the core's RAM write
//                port and, on done, walks it one parent/child compare per
//                cycle to verify the max-heap property and sequential
//                addressing. Reports a held verdict and offers read-back.
//  Revision    : 1.0  initial release
// ============================================================================
module heap_dump_checker
  import mpq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ram_valid,
  input  logic [7:0] ram_a,
  input  logic [7:0] ram_d,
  input  logic       done,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       check_valid,
  output logic       heap_ok,
  output logic [1:0] err_code,
  output logic [7:0] err_idx,
  output logic [7:0] entries,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  // Index/limit wide enough to hold DEPTH itself.
  typedef logic [AW:0] idx_t;

  chk_state_t state, state_nx;

  logic [7:0] wr_cnt;
  logic       seq_err;
  logic       ovf;
  logic [7:0] seq_addr;
  logic [7:0] ovf_addr;
  idx_t       idx;
  idx_t       n_chk;

  logic [7:0] par_data;
  logic [7:0] chd_data;
  logic [7:0] rb_data;

  logic       write_en;
  logic       wr_in_range;
  logic [7:0] wr_cnt_inc;
  logic [7:0] wr_cnt_nx;
  idx_t       n_next;

  logic       go_report;
  logic       idx_inc;
  logic       v_ok;
  logic [1:0] v_code;
  logic [7:0] v_idx;

  assign write_en    = (state == ST_IDLE) && ram_valid;
  assign wr_in_range = ({1'b0, ram_a} < DEPTH9);
  assign wr_cnt_inc  = (wr_cnt == 8'hFF) ? wr_cnt : wr_cnt + 8'd1;
  // Count as it will stand after this cycle, so a write alongside done counts.
  assign wr_cnt_nx   = write_en ? wr_cnt_inc : wr_cnt;
  assign n_next      = ({1'b0, wr_cnt_nx} < DEPTH9) ? idx_t'(wr_cnt_nx) : idx_t'(DEPTH);

  heap_cap_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .we       (write_en && wr_in_range),
    .wr_addr  (AW'(ram_a)),
    .wr_data  (ram_d),
    .par_addr (AW'((idx - idx_t'(1)) >> 1)),
    .par_data (par_data),
    .chd_addr (AW'(idx)),
    .chd_data (chd_data),
    .rb_addr  (AW'(rd_addr)),
    .rb_data  (rb_data)
  );

  assign rd_data     = ({1'b0, rd_addr} < DEPTH9) ? rb_data : 8'd0;
  assign check_valid = (state == ST_REPORT);
  assign busy        = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and the verdict that would be latched on entry to REPORT.
  always_comb begin
    state_nx  = state;
    go_report = 1'b0;
    idx_inc   = 1'b0;
    v_ok      = 1'b0;
    v_code    = ERR_NONE;
    v_idx     = IDX_NONE;
    case (state)
      ST_IDLE: begin
        if (done) begin
          state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ovf) begin
          go_report = 1'b1;
          v_code    = ERR_OVF;
          v_idx     = ovf_addr;
        end else if (seq_err) begin
          go_report = 1'b1;
          v_code    = ERR_SEQ;
          v_idx     = seq_addr;
        end else if (idx >= n_chk) begin
          go_report = 1'b1;
          v_ok      = 1'b1;
        end else if (par_data < chd_data) begin
          go_report = 1'b1;
          v_code    = ERR_HEAP;
          v_idx     = 8'(idx);
        end else begin
          idx_inc = 1'b1;
        end
        if (go_report) begin
          state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Capture counters, sticky error flags and the check walk index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= 8'd0;
      seq_err  <= 1'b0;
      ovf      <= 1'b0;
      seq_addr <= 8'd0;
      ovf_addr <= 8'd0;
      idx      <= idx_t'(1);
      n_chk    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ram_valid) begin
            wr_cnt <= wr_cnt_inc;
            if (!seq_err && (ram_a != wr_cnt)) begin
              seq_err  <= 1'b1;
              seq_addr <= ram_a;
            end
            if (!ovf && !wr_in_range) begin
              ovf      <= 1'b1;
              ovf_addr <= ram_a;
            end
          end
          if (done) begin
            idx   <= idx_t'(1);
            n_chk <= n_next;
          end
        end
        ST_CHECK: begin
          if (idx_inc) begin
            idx <= idx + idx_t'(1);
          end
        end
        ST_REPORT: begin
          wr_cnt  <= 8'd0;
          seq_err <= 1'b0;
          ovf     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Held verdict registers, loaded on the transition into REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heap_ok  <= 1'b0;
      err_code <= ERR_NONE;
      err_idx  <= IDX_NONE;
      entries  <= 8'd0;
    end else if (go_report) begin
      heap_ok  <= v_ok;
      err_code <= v_code;
      err_idx  <= v_idx;
      entries  <= wr_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_heap_dump_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heap_dump_checker
//  Description : Self-checking bench for heap_dump_checker: directed vector
//                table, hand-written corner sequences and randomized dumps
//                checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_heap_dump_checker;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_valid;
  logic [7:0] ram_a;
  logic [7:0] ram_d;
  logic       done;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       check_valid;
  logic       heap_ok;
  logic [1:0] err_code;
  logic [7:0] err_idx;
  logic [7:0] entries;
  logic       busy;

  heap_dump_checker #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_valid   (ram_valid),
    .ram_a       (ram_a),
    .ram_d       (ram_d),
    .done        (done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .check_valid (check_valid),
    .heap_ok     (heap_ok),
    .err_code    (err_code),
    .err_idx     (err_idx),
    .entries     (entries),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cv_count = 0;

  // Count verdict strobes, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_valid) cv_count++;
  end

  // Bench-side image of the capture buffer.
  logic [7:0] model_mem [DEPTH];
  bit         model_vld [DEPTH];

  logic [7:0] q_a [$];
  logic [7:0] q_d [$];

  logic [7:0] base_data [16] = '{90,80,70,60,50,40,30,20,10,9,8,7,6,5,4,3};

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive the queued writes, pulse done, wait for the verdict. lat = k means
  // check_valid was seen in cycle T+k where T is the done cycle.
  task automatic send_dump(input bit coincide, input int redone_at, output int lat);
    int nw;
    nw = q_a.size();
    for (int k = 0; k < nw; k++) begin
      ram_valid = 1'b1;
      ram_a     = q_a[k];
      ram_d     = q_d[k];
      if (coincide && k == nw - 1) done = 1'b1;
      if (q_a[k] < DEPTH) begin
        model_mem[q_a[k][3:0]] = q_d[k];
        model_vld[q_a[k][3:0]] = 1'b1;
      end
      @(posedge clk); #1;
    end
    ram_valid = 1'b0;
    if (!(coincide && nw > 0)) begin
      done = 1'b1;
      @(posedge clk); #1;
    end
    done = 1'b0;
    chk("busy_after_done", busy, 1);
    lat = 1;
    while (!check_valid && lat < 300) begin
      if (lat == redone_at) done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      lat++;
    end
  endtask

  // After a verdict: it must be a one-cycle strobe and busy must drop.
  task automatic post_verdict();
    @(posedge clk); #1;
    chk("cv_one_cycle", check_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic readback(input int nchecks);
    int a;
    for (int r = 0; r < nchecks; r++) begin
      a = $urandom_range(0, 19);
      rd_addr = 8'(a);
      #1;
      if (a >= DEPTH) chk("rd_oob", rd_data, 0);
      else if (model_vld[a]) chk($sformatf("rd_mem%0d", a), rd_data, model_mem[a]);
    end
  endtask

  // Reference: apply the dump rules with plain arithmetic over the write list.
  task automatic model_expect(output bit ok, output int code, output int idx,
                              output int lat, output int ent);
    int cnt, n, oa, sa, fi;
    bit sq, ov, fail;
    cnt = 0; sq = 0; ov = 0; oa = 0; sa = 0; fail = 0; fi = 0;
    foreach (q_a[k]) begin
      if (!ov && q_a[k] >= DEPTH) begin ov = 1; oa = q_a[k]; end
      if (!sq && q_a[k] != cnt) begin sq = 1; sa = q_a[k]; end
      cnt = (cnt < 255) ? cnt + 1 : 255;
    end
    n = (cnt < DEPTH) ? cnt : DEPTH;
    for (int i = 1; i < n; i++) begin
      if (!fail && model_mem[(i - 1) / 2] < model_mem[i]) begin fail = 1; fi = i; end
    end
    ent = cnt;
    if (ov)        begin ok = 0; code = 3; idx = oa;  lat = 2; end
    else if (sq)   begin ok = 0; code = 2; idx = sa;  lat = 2; end
    else if (fail) begin ok = 0; code = 1; idx = fi;  lat = fi + 1; end
    else           begin ok = 1; code = 0; idx = 255; lat = (n == 0) ? 2 : n + 1; end
  endtask

  typedef struct {
    string      name;
    int         n_wr;
    int         mode;     // 0 plain, 1 data override at pos, 2 last address = pos
    int         pos;
    logic [7:0] val;
    bit         e_ok;
    int         e_code;
    int         e_idx;
    int         e_lat;
    int         e_ent;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, cv0;
    bit m_ok;
    int m_code, m_idx, m_lat, m_ent;

    vecs[0] = '{"full_pass",  16, 0, 0,  8'd0,  1'b1, 0, 255, 17, 16};
    vecs[1] = '{"heap_fail4", 16, 1, 4,  8'd85, 1'b0, 1, 4,   5,  16};
    vecs[2] = '{"seq_err",    3,  2, 3,  8'd0,  1'b0, 2, 3,   2,  3};
    vecs[3] = '{"ovf",        1,  2, 16, 8'd0,  1'b0, 3, 16,  2,  1};
    vecs[4] = '{"empty",      0,  0, 0,  8'd0,  1'b1, 0, 255, 2,  0};
    vecs[5] = '{"heap_fail2", 5,  1, 2,  8'd95, 1'b0, 1, 2,   3,  5};
    vecs[6] = '{"single",     1,  0, 0,  8'd0,  1'b1, 0, 255, 2,  1};

    foreach (model_vld[i]) model_vld[i] = 1'b0;
    rst = 1'b1; ram_valid = 1'b0; ram_a = 8'd0; ram_d = 8'd0; done = 1'b0; rd_addr = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_check_valid", check_valid, 0);
    chk("rst_heap_ok", heap_ok, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_idx", err_idx, 255);
    chk("rst_entries", entries, 0);
    chk("rst_busy", busy, 0);
    rd_addr = 8'd20; #1;
    chk("rst_rd_oob", rd_data, 0);

    // Directed table.
    foreach (vecs[v]) begin
      q_a.delete(); q_d.delete();
      for (int k = 0; k < vecs[v].n_wr; k++) begin
        q_a.push_back((vecs[v].mode == 2 && k == vecs[v].n_wr - 1) ? 8'(vecs[v].pos) : 8'(k));
        q_d.push_back((vecs[v].mode == 1 && k == vecs[v].pos) ? vecs[v].val : base_data[k]);
      end
      send_dump(1'b0, 0, lat);
      chk({vecs[v].name, "_lat"}, lat, vecs[v].e_lat);
      chk({vecs[v].name, "_ok"}, heap_ok, vecs[v].e_ok);
      chk({vecs[v].name, "_code"}, err_code, vecs[v].e_code);
      chk({vecs[v].name, "_idx"}, err_idx, vecs[v].e_idx);
      chk({vecs[v].name, "_entries"}, entries, vecs[v].e_ent);
      post_verdict();
      readback(2);
    end

    // Last write coincident with done; a second done during CHECK is ignored.
    q_a.delete(); q_d.delete();
    for (int k = 0; k < 16; k++) begin q_a.push_back(8'(k)); q_d.push_back(base_data[k]); end
    cv0 = cv_count;
    send_dump(1'b1, 5, lat);
    chk("coinc_lat", lat, 17);
    chk("coinc_ok", heap_ok, 1);
    chk("coinc_entries", entries, 16);
    post_verdict();
    repeat (25) @(posedge clk);
    #1;
    chk("coinc_one_verdict", cv_count - cv0, 1);

    // Reset mid-CHECK aborts without a verdict.
    cv0 = cv_count;
    for (int k = 0; k < 16; k++) begin
      ram_valid = 1'b1; ram_a = 8'(k); ram_d = base_data[k];
      @(posedge clk); #1;
    end
    ram_valid = 1'b0; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_check_valid", check_valid, 0);
    chk("midrst_heap_ok", heap_ok, 0);
    chk("midrst_err_code", err_code, 0);
    chk("midrst_err_idx", err_idx, 255);
    chk("midrst_entries", entries, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (model_vld[i]) model_vld[i] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_verdict", cv_count - cv0, 0);

    q_a.delete(); q_d.delete();
    q_a.push_back(8'd0); q_d.push_back(8'd9);
    q_a.push_back(8'd1); q_d.push_back(8'd5);
    q_a.push_back(8'd2); q_d.push_back(8'd7);
    send_dump(1'b0, 0, lat);
    chk("after_rst_lat", lat, 4);
    chk("after_rst_ok", heap_ok, 1);
    chk("after_rst_entries", entries, 3);
    post_verdict();

    // Randomized dumps against the reference.
    for (int r = 0; r < 40; r++) begin
      int nw, kind, v, pos;
      q_a.delete(); q_d.delete();
      nw = $urandom_range(0, 16);
      kind = $urandom_range(0, 3);
      v = 255;
      for (int k = 0; k < nw; k++) begin
        v = v - $urandom_range(0, 15);
        if (v < 0) v = 0;
        q_a.push_back(8'(k));
        q_d.push_back(8'(v));
      end
      if (nw > 0) begin
        pos = $urandom_range(0, nw - 1);
        if (kind == 1) q_d[pos] = 8'($urandom_range(0, 255));
        if (kind == 2) q_a[pos] = 8'($urandom_range(0, 15));
        if (kind == 3) q_a[pos] = 8'($urandom_range(16, 255));
      end
      send_dump(($urandom_range(0, 1) == 1), 0, lat);
      model_expect(m_ok, m_code, m_idx, m_lat, m_ent);
      chk($sformatf("rnd%0d_lat", r), lat, m_lat);
      chk($sformatf("rnd%0d_ok", r), heap_ok, m_ok);
      chk($sformatf("rnd%0d_code", r), err_code, m_code);
      chk($sformatf("rnd%0d_idx", r), err_idx, m_idx);
      chk($sformatf("rnd%0d_entries", r), entries, m_ent);
      post_verdict();
      readback(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heap_dump_checker.md
# heap_dump_checker

Downstream monitor for the max-priority-queue core: captures the heap array the core streams out over its RAM write port (`RAM_valid`/`RAM_A`/`RAM_D`), and on the core's `done` pulse walks the captured array to confirm the max-heap property and sequential addressing. It reports one pass/fail verdict per dump plus the first offending index, and offers a read-back port so the bench or a host can inspect the captured image.

## Interface
- `DEPTH`, 16: capture buffer entries; must be a power of 2, at most 256; matches the core's 4-bit heap size.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ram_valid` input 1: write strobe from the core.
- `ram_a` input 8: write address, expected to be 0,1,2,… in order.
- `ram_d` input 8: write data.
- `done` input 1: one-cycle end-of-dump pulse from the core.
- `rd_addr` input 8: read-back address.
- `rd_data` output 8: combinational `mem[rd_addr]`; 0 when `rd_addr >= DEPTH`.
- `check_valid` output 1: one-cycle verdict strobe.
- `heap_ok` output 1: verdict; held until the next verdict.
- `err_code` output 2: 0 none, 1 heap violation, 2 address sequence error, 3 overflow (`ram_a >= DEPTH`); held.
- `err_idx` output 8: first failing child index for code 1, offending `ram_a` for codes 2/3, 8'hFF otherwise; held.
- `entries` output 8: number of writes captured in the last dump; held.
- `busy` output 1: high in CHECK and REPORT.

## Operation
States: IDLE, CHECK, REPORT.
- IDLE
  - On each `ram_valid`, store `mem[ram_a] <= ram_d` when `ram_a < DEPTH`.
  - `wr_cnt` increments, saturating at 255.
  - The first write with `ram_a != wr_cnt` latches sticky `seq_err` and its address; a write with `ram_a >= DEPTH` latches sticky `ovf` and its address. The write is dropped and `wr_cnt` still increments.
  - On `done`, go to CHECK with `i = 1`, `n = min(wr_cnt', DEPTH)`. `wr_cnt'` includes a `ram_valid` in the same cycle, so a write coinciding with `done` is captured and counted.
- CHECK (one compare per cycle)
  - If `ovf` or `seq_err`: go straight to REPORT.
  - Else if `i >= n`: REPORT with pass.
  - Else if `mem[(i-1)>>1] < mem[i]` (unsigned): REPORT with fail, `err_idx = i`.
  - Else `i++`.
- REPORT (one cycle)
  - Drive `check_valid = 1` and register `heap_ok`, `err_code`, `err_idx`, `entries`.
  - Priority: overflow > sequence > heap.
  - Clear `wr_cnt`, `seq_err`, `ovf`. Return to IDLE.
- `ram_valid` or `done` while `busy` is ignored. Memory is not modified during CHECK, and a `done` arriving then does not queue.
- Empty dump (`done` with no writes): pass, `entries = 0`, `err_idx = FF`.
- Memory contents persist across dumps; only indices below `n` are checked.

## Timing
- Reset values:
  - outputs: `check_valid = 0`, `heap_ok = 0`, `err_code = 0`, `err_idx = FF`, `entries = 0`, `busy = 0`
  - state: IDLE, `wr_cnt = 0`, flags clear
  - memory contents: don't-care; `rd_data` is unspecified until written.
- Reset mid-CHECK aborts without a verdict.
- With `done` at cycle T, CHECK starts at T+1.
  - Pass with n ≥ 1: `check_valid` at T+n+1.
  - Pass with n = 0: `check_valid` at T+2.
  - Heap failure at child i: `check_valid` at T+i+1.
  - Sequence or overflow error: `check_valid` at T+2.
- Verdict outputs update in the same cycle as `check_valid`.
- `busy` is high from T+1 through the REPORT cycle inclusive.
- A new dump may begin the cycle after REPORT.

## Structure
- Shared package `mpq_pkg` holds the state enum and the `ERR_NONE`/`ERR_HEAP`/`ERR_SEQ`/`ERR_OVF` constants, and defines the `IDX_NONE = 8'hFF` constant.
- One sub-module, `heap_cap_mem`: DEPTH×8 register array with 1 write port and 3 asynchronous read ports (parent, child, read-back).
- The FSM, counters and flags live in the top module.

## Test plan
- Writes 0..15 carrying 90,80,70,60,50,40,30,20,10,9,8,7,6,5,4,3, then `done` -> `check_valid` 17 cycles later; `heap_ok = 1`, `err_code = 0`, `entries = 16`, `err_idx = FF`.
- Same data but `mem[4] = 85` -> fail at child 4 (parent 1 holds 80): `check_valid` at T+5, `err_code = 1`, `err_idx = 4`.
- Writes to addresses 0,1,3 -> `err_code = 2`, `err_idx = 3`, verdict at T+2.
- Write to address 16 -> `err_code = 3`, `err_idx = 16`.
- Last write coincident with `done` -> the write is counted (`entries = 16`, pass). A `done` pulsed again during CHECK is ignored, giving exactly one `check_valid`.
- Assert `rst` mid-CHECK -> no `check_valid`, all outputs return to reset values. A following 3-entry dump 9,5,7 then passes with `entries = 3`.
